// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per clock.
// Values above 10^DIGITS-1 saturate the result to all nines and raise overflow.
module bcd_convert_seq #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      num_bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int                  CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [WIDTH-1:0]      shift_q;
  logic [4*DIGITS-1:0]   scratch_q;
  logic                  ovf_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  overflow_q;

  logic [4*DIGITS-1:0]   scratch_adj;
  logic [4*DIGITS-1:0]   scratch_d;
  logic [WIDTH-1:0]      shift_d;
  logic                  carry_d;
  logic                  ovf_d;

  // One double-dabble step. A bit leaving the top digit means the partial
  // value has reached 10^DIGITS; partial values only grow, so it is sticky.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {carry_d, scratch_d} = {scratch_adj, shift_q[WIDTH-1]};
    shift_d              = shift_q << 1;
    ovf_d                = ovf_q | carry_d;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q   <= num_bin;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          ovf_q     <= ovf_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            bcd_q      <= ovf_d ? ALL_NINES : scratch_d;
            overflow_q <= ovf_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: doc/bcd_convert_seq.md
BCD_CONVERT_SEQ -- requirements
Module: bcd_convert_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the binary input width; legal range 1..32.
REQ-002 The block SHALL have parameter DIGITS, default 2, giving the number of BCD output digits; legal range 1..10.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to convert num_bin; sampled only in IDLE.
REQ-007 num_bin  input  WIDTH  unsigned binary value, sampled on the accepting edge only.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse: bcd/overflow updated.
REQ-010 bcd  output  4*DIGITS  packed BCD result; digit i in bits [4i+3:4i], digit 0 = units.
REQ-011 overflow  output  1  last accepted value exceeded 10^DIGITS-1.

Function
REQ-012 FSM states SHALL be IDLE and CONV; a step counter SHALL count 0..WIDTH-1.
REQ-013 In IDLE with start=1 at edge k: capture num_bin into a shift register, clear the BCD scratch register, set counter=0, enter CONV, busy=1 from edge k.
REQ-014 In IDLE with start=0: state and all outputs hold, except done, which SHALL be 0.
REQ-015 Each CONV edge SHALL perform one double-dabble step: add 3 to every scratch digit >=5, then shift {scratch, shift register} left by 1.
REQ-016 After step WIDTH-1 (edge k+WIDTH), the block SHALL load bcd and overflow, pulse done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-017 Latency from the accepting edge to done high SHALL be WIDTH cycles; throughput SHALL be one conversion per WIDTH+1 cycles at most.
REQ-018 start during CONV SHALL be ignored; num_bin changes during CONV SHALL not affect the result.
REQ-019 start high in the done cycle (state IDLE) SHALL be accepted (back-to-back).
REQ-020 overflow SHALL be computed from the captured value: overflow=1 iff value > 10^DIGITS-1.
REQ-021 When overflow=1, bcd SHALL saturate to all digits 9; otherwise bcd SHALL equal the exact decimal value.
REQ-022 bcd and overflow SHALL hold their last values between conversions, including while busy.
REQ-023 Every digit of bcd SHALL be in 0..9 at all times.
REQ-024 If WIDTH is small enough that the maximum input never overflows, overflow SHALL stay 0.

Reset
REQ-025 When reset=1 at a clock edge: state=IDLE, counter=0, busy=0, done=0, bcd=0, overflow=0.
REQ-026 Reset during CONV SHALL abort the conversion with no done pulse.
REQ-027 Reset SHALL take priority over start on the same edge.
REQ-028 The first start after reset release SHALL be accepted on the following edge.

Verification
REQ-029 WIDTH=6, DIGITS=2: num_bin=45, start 1 cycle -> busy 6 cycles, done pulse at edge+6, bcd=0x45, overflow=0.
REQ-030 WIDTH=6, DIGITS=2: sweep 0..63 -> bcd equals the decimal value (e.g. 9->0x09, 10->0x10, 59->0x59, 60->0x60, 63->0x63), overflow=0.
REQ-031 WIDTH=8, DIGITS=2: num_bin=200 -> overflow=1, bcd=0x99; then 99 -> overflow=0, bcd=0x99; then 100 -> overflow=1.
REQ-032 WIDTH=6: start=1 with num_bin=12, then start=1 with num_bin=34 while busy -> single done, bcd=0x12.
REQ-033 Reset asserted 3 cycles into a conversion of 57 -> no done, bcd=0x00, busy=0; a new start of 21 then gives bcd=0x21.
REQ-034 start held high continuously with num_bin=7 then 8 -> conversions back-to-back every 7 cycles, each done correct.
